regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file for the pipelined BRISC-V cores, replacing the fixed two-port register file. Adds a configurable number of read ports, a per-register busy scoreboard for hazard/stall logic in decode, and a sequential post-reset clear engine that zeroes every register before the file reports ready. Same-cycle write-to-read bypass is optional via a macro. Sits in the decode stage: read ports feed operand muxes; the write port is driven from writeback.

## Interface
- REG_DATA_WIDTH, 32, register width in bits
- REG_SEL_BITS, 5, register index width; depth = 1<<REG_SEL_BITS
- NUM_READ_PORTS, 2, number of independent read ports (≥1)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear_req  in  1  request a full re-clear (sampled only in RUN)
- ready  out  1  high when the file is usable (RUN state)
- read_sel  in  NUM_READ_PORTS*REG_SEL_BITS  packed read indices; port k at bits [k*REG_SEL_BITS +: REG_SEL_BITS]
- read_data  out  NUM_READ_PORTS*REG_DATA_WIDTH  packed read data, same packing
- read_busy  out  NUM_READ_PORTS  busy flag of the register selected on each port
- wEn  in  1  write enable
- write_sel  in  REG_SEL_BITS  write index
- write_data  in  REG_DATA_WIDTH  write data
- reserve_en  in  1  mark a register busy (producer issued)
- reserve_sel  in  REG_SEL_BITS  register to mark busy

## Operation
- States: CLEAR, RUN. Reset (async) forces CLEAR, clear_idx=0, busy[all]=0, ready=0.
- CLEAR: each cycle writes 0 to register[clear_idx], clear_idx++. On the cycle clear_idx == depth-1 is written, next state RUN. wEn, reserve_en ignored. read_data all 0, read_busy all 0.
- RUN: ready=1. clear_req=1 → next state CLEAR, clear_idx=0, busy cleared on entry; writes in that same cycle still complete.
- Write: in RUN, wEn & write_sel≠0 → register[write_sel] <= write_data at clock edge. Writes to index 0 are dropped.
- Read: combinational, read_data[k] = register[read_sel[k]]; index 0 always returns 0 regardless of array contents.
- Scoreboard: in RUN, wEn & write_sel≠0 clears busy[write_sel]; reserve_en & reserve_sel≠0 sets busy[reserve_sel]. Same index both in one cycle → set wins (new producer). busy[0] constant 0.
- read_busy[k] = busy[read_sel[k]] (registered value, subject to bypass below).
- Multiple read ports may select the same index; all return identical data.

## Timing
- Reset to ready: exactly 1<<REG_SEL_BITS cycles after reset deasserts (32 for defaults); same for clear_req.
- Write latency: 1 cycle; data visible on read ports the cycle after the write edge (0 cycles with bypass).
- Reserve: busy visible the cycle after the reserve edge.
- Reset mid-CLEAR or mid-RUN: immediate return to CLEAR, clear_idx=0, ready=0, busy=0; clear restarts from index 0.
- Outputs at reset: ready=0, read_data=0, read_busy=0.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if wEn & write_sel≠0 & write_sel==read_sel[k], read_data[k]=write_data and read_busy[k]=0 in that same cycle, unless reserve_en re-targets the same index that cycle (then read_busy[k]=1, data still bypassed).
- Undefined: reads return the stored array value; same-cycle write is seen one cycle later; read_busy reflects registered busy only.

## Test plan
- Reset, deassert → ready=0 for 32 cycles, ready=1 on cycle 32; all 32 registers read 0 on port 0 and port 1.
- RUN: write x5=0xDEADBEEF → next cycle read_sel={5,5} gives 0xDEADBEEF on both ports; write x0=0x1234 → x0 still reads 0.
- Reserve x7, then 3 cycles later write x7=0x55 → read_busy=1 for cycles 1–3 after reserve, 0 the cycle after the write; same-cycle reserve+write x7 → busy stays 1.
- Bypass build: write x9=0xA5A5A5A5 while read_sel[0]=9 → read_data[0]=0xA5A5A5A5 same cycle; non-bypass build → old value, new value next cycle.
- clear_req in RUN after writing x3=0x77 → ready drops next cycle, 32 cycles later ready=1 and x3 reads 0; wEn during CLEAR has no effect.
- Assert reset on CLEAR cycle 10 → ready=0, busy=0, full 32-cycle clear restarts after deassert.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a busy scoreboard and a sequential post-reset clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned REG_SEL_BITS   = 5,
    parameter int unsigned NUM_READ_PORTS = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     clear_req,
    output logic                                     ready,
    input  logic [NUM_READ_PORTS*REG_SEL_BITS-1:0]   read_sel,
    output logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]                read_busy,
    input  logic                                     wEn,
    input  logic [REG_SEL_BITS-1:0]                  write_sel,
    input  logic [REG_DATA_WIDTH-1:0]                write_data,
    input  logic                                     reserve_en,
    input  logic [REG_SEL_BITS-1:0]                  reserve_sel
);

    localparam int unsigned Depth = 1 << REG_SEL_BITS;

    typedef enum logic {StClear, StRun} state_e;

    state_e                    state_q, state_d;
    logic [REG_SEL_BITS-1:0]   clear_idx_q, clear_idx_d;
    logic [Depth-1:0]          busy_q, busy_d;
    logic [REG_DATA_WIDTH-1:0] regs_q [Depth];

    logic                      run;
    logic                      wr_en;
    logic                      rsv_en;
    logic                      mem_we;
    logic [REG_SEL_BITS-1:0]   mem_wsel;
    logic [REG_DATA_WIDTH-1:0] mem_wdata;

    logic [REG_SEL_BITS-1:0]   port_sel  [NUM_READ_PORTS];
    logic [REG_DATA_WIDTH-1:0] port_data [NUM_READ_PORTS];
    logic                      port_busy [NUM_READ_PORTS];

    assign run    = (state_q == StRun);
    assign ready  = run;
    assign wr_en  = run && wEn && (write_sel != '0);
    assign rsv_en = run && reserve_en && (reserve_sel != '0);

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        unique case (state_q)
            StClear: begin
                clear_idx_d = clear_idx_q + REG_SEL_BITS'(1);
                if (&clear_idx_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clear_req) begin
                    state_d     = StClear;
                    clear_idx_d = '0;
                end
            end
            default: begin
                state_d     = StClear;
                clear_idx_d = '0;
            end
        endcase
    end

    // The single array write port is shared between the clear engine and writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_wsel  = write_sel;
        mem_wdata = write_data;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_wsel  = clear_idx_q;
            mem_wdata = '0;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Reserve is applied after the write-back clear so a new producer wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (clear_req) begin
                busy_d = '0;
            end else begin
                if (wr_en) begin
                    busy_d[write_sel] = 1'b0;
                end
                if (rsv_en) begin
                    busy_d[reserve_sel] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            port_sel[k]  = read_sel[k*REG_SEL_BITS +: REG_SEL_BITS];
            port_data[k] = regs_q[port_sel[k]];
            port_busy[k] = busy_q[port_sel[k]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (write_sel == port_sel[k])) begin
                port_data[k] = write_data;
                port_busy[k] = rsv_en && (reserve_sel == port_sel[k]);
            end
`endif
            if (!run || (port_sel[k] == '0)) begin
                port_data[k] = '0;
                port_busy[k] = 1'b0;
            end
            read_data[k*REG_DATA_WIDTH +: REG_DATA_WIDTH] = port_data[k];
            read_busy[k]                                 = port_busy[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StClear;
            clear_idx_q <= '0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            busy_q      <= busy_d;
        end
    end

    // Array contents need no reset: the clear engine zeroes them before ready rises.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            regs_q[mem_wsel] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of regfile_mp against a cycle-level model of the register file.
module tb_regfile_mp;

    localparam int W     = 32;
    localparam int S     = 5;
    localparam int NP    = 2;
    localparam int DEPTH = 1 << S;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              clear_req = 1'b0;
    logic              ready;
    logic [NP*S-1:0]   read_sel = '0;
    logic [NP*W-1:0]   read_data;
    logic [NP-1:0]     read_busy;
    logic              wEn = 1'b0;
    logic [S-1:0]      write_sel = '0;
    logic [W-1:0]      write_data = '0;
    logic              reserve_en = 1'b0;
    logic [S-1:0]      reserve_sel = '0;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_regs [DEPTH];
    bit           m_busy [DEPTH];
    int           m_clear_left;

    regfile_mp #(
        .REG_DATA_WIDTH (W),
        .REG_SEL_BITS   (S),
        .NUM_READ_PORTS (NP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear_req   (clear_req),
        .ready       (ready),
        .read_sel    (read_sel),
        .read_data   (read_data),
        .read_busy   (read_busy),
        .wEn         (wEn),
        .write_sel   (write_sel),
        .write_data  (write_data),
        .reserve_en  (reserve_en),
        .reserve_sel (reserve_sel)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit           run;
        logic [S-1:0] sel;
        logic [W-1:0] ed;
        bit           eb;
        run = (m_clear_left == 0) && !reset;
        chk({tag, ".ready"}, W'(ready), W'(run));
        for (int k = 0; k < NP; k++) begin
            sel = read_sel[k*S +: S];
            ed  = '0;
            eb  = 1'b0;
            if (run && sel != 0) begin
                ed = m_regs[sel];
                eb = m_busy[sel];
`ifdef REGFILE_BYPASS_EN
                if (wEn && write_sel == sel) begin
                    ed = write_data;
                    eb = reserve_en && (reserve_sel == sel);
                end
`endif
            end
            chk($sformatf("%s.data%0d", tag, k), read_data[k*W +: W], ed);
            chk($sformatf("%s.busy%0d", tag, k), W'(read_busy[k]), W'(eb));
        end
    endtask

    task automatic model_edge();
        if (m_clear_left > 0) begin
            m_regs[DEPTH - m_clear_left] = '0;
            m_clear_left--;
        end else begin
            if (wEn && write_sel != 0) begin
                m_regs[write_sel] = write_data;
                m_busy[write_sel] = 1'b0;
            end
            if (reserve_en && reserve_sel != 0) m_busy[reserve_sel] = 1'b1;
            if (clear_req) begin
                m_clear_left = DEPTH;
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic step(input string tag, input bit we, input logic [S-1:0] ws,
                        input logic [W-1:0] wd, input bit re, input logic [S-1:0] rs,
                        input bit cr, input logic [S-1:0] r0, input logic [S-1:0] r1);
        wEn         = we;
        write_sel   = ws;
        write_data  = wd;
        reserve_en  = re;
        reserve_sel = rs;
        clear_req   = cr;
        read_sel    = {r1, r0};
        #1 check_outputs(tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle(input string tag, input logic [S-1:0] r0, input logic [S-1:0] r1);
        step(tag, 1'b0, '0, '0, 1'b0, '0, 1'b0, r0, r1);
    endtask

    task automatic do_reset(input string tag);
        wEn        = 1'b0;
        reserve_en = 1'b0;
        clear_req  = 1'b0;
        read_sel   = {S'(3), S'(7)};
        reset      = 1'b1;
        m_clear_left = DEPTH;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        #1 check_outputs({tag, ".in"});
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outputs({tag, ".hold"});
        reset = 1'b0;
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 'x;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_clear_left = DEPTH;
        @(negedge clock);

        do_reset("rst0");
        for (int i = 0; i < DEPTH; i++) idle("clr0", S'(i), S'(DEPTH - 1 - i));
        chk("ready_after_clear", W'(ready), W'(1));
        for (int i = 0; i < DEPTH; i++) idle("zero", S'(i), S'(DEPTH - 1 - i));

        step("wr5", 1'b1, S'(5), 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0);
        read_sel = {S'(5), S'(5)};
        #1 chk("x5_p0", read_data[W-1:0], 32'hDEADBEEF);
        chk("x5_p1", read_data[2*W-1:W], 32'hDEADBEEF);
        idle("rd5", S'(5), S'(5));
        step("wr0", 1'b1, S'(0), 32'h1234, 1'b0, '0, 1'b0, '0, '0);
        idle("rd0", S'(0), S'(0));

        step("rsv7", 1'b0, '0, '0, 1'b1, S'(7), 1'b0, S'(7), S'(7));
        idle("rsv7_c1", S'(7), S'(7));
        idle("rsv7_c2", S'(7), S'(7));
        step("wr7", 1'b1, S'(7), 32'h55, 1'b0, '0, 1'b0, S'(7), S'(7));
        idle("rd7", S'(7), S'(7));
        step("rsvwr7", 1'b1, S'(7), 32'h66, 1'b1, S'(7), 1'b0, S'(7), S'(0));
        read_sel = {S'(0), S'(7)};
        #1 chk("busy7_sticky", W'(read_busy[0]), W'(1));
        step("wr7b", 1'b1, S'(7), 32'h77, 1'b0, '0, 1'b0, S'(7), S'(7));

        idle("pre9", S'(9), S'(9));
        step("byp9", 1'b1, S'(9), 32'hA5A5A5A5, 1'b0, '0, 1'b0, S'(9), S'(9));
        idle("rd9", S'(9), S'(9));

        step("wr3", 1'b1, S'(3), 32'h77, 1'b0, '0, 1'b0, S'(3), S'(3));
        step("creq", 1'b0, '0, '0, 1'b1, S'(4), 1'b1, S'(3), S'(4));
        for (int i = 0; i < DEPTH; i++) begin
            step("clr_wr", 1'b1, S'(3), $urandom, 1'b1, S'(3), 1'b0, S'(3), S'(i));
        end
        idle("rd3", S'(3), S'(4));

        for (int i = 0; i < 800; i++) begin
            logic [S-1:0] ws, r0, r1;
            ws = S'($urandom);
            r0 = ($urandom % 4 == 0) ? ws : S'($urandom);
            r1 = ($urandom % 4 == 0) ? r0 : S'($urandom);
            step("rand", bit'($urandom % 2), ws, $urandom, ($urandom % 3 == 0),
                 ($urandom % 4 == 0) ? ws : S'($urandom), ($urandom % 64 == 0), r0, r1);
        end

        do_reset("rst_run");
        for (int i = 0; i < 10; i++) idle("clr1", S'(i), S'(i + 1));
        do_reset("rst_mid");
        for (int i = 0; i < DEPTH; i++) idle("clr2", S'(1), S'(i));
        for (int i = 0; i < 40; i++) begin
            step("rand2", bit'($urandom % 2), S'($urandom), $urandom, bit'($urandom % 2),
                 S'($urandom), 1'b0, S'($urandom), S'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
